// File: rtl/alu_rs_pkg.sv
// Shared widths, tag encoding, ALU opcodes and the station slot layout
// used by the integer ALU reservation station.
package alu_rs_pkg;

  localparam int COMMON_WIDTH   = 32;
  localparam int INST_TAG_WIDTH = 4;
  localparam int ALU_OP_WIDTH   = 6;

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = 4'hF;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 6'h01,
    ALU_SUB = 6'h02,
    ALU_AND = 6'h03,
    ALU_OR  = 6'h04,
    ALU_XOR = 6'h05,
    ALU_SLL = 6'h06,
    ALU_SRL = 6'h07,
    ALU_SLT = 6'h08
  } alu_op_e;

  typedef struct packed {
    logic                      busy;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [INST_TAG_WIDTH-1:0] dtag;
    logic [INST_TAG_WIDTH-1:0] q1;
    logic [COMMON_WIDTH-1:0]   v1;
    logic [INST_TAG_WIDTH-1:0] q2;
    logic [COMMON_WIDTH-1:0]   v2;
    logic [1:0]                rank;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_select.sv
// Combinational oldest-ready picker: grants the ready slot with the smallest
// rank. Ranks of busy slots are unique, so ties cannot occur.
module rs_select #(
  parameter int ENTRIES = 4,
  parameter int RANK_W  = 2,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0]             ready,
  input  logic [ENTRIES-1:0][RANK_W-1:0] rank,
  output logic [IDX_W-1:0]               grant,
  output logic                           any_ready
);

  logic [RANK_W-1:0] best_rank_s;

  // Linear scan keeping the lowest rank among ready slots.
  always_comb begin
    grant       = '0;
    any_ready   = 1'b0;
    best_rank_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!any_ready || (rank[i] < best_rank_s))) begin
        grant       = IDX_W'(i);
        best_rank_s = rank[i];
        any_ready   = 1'b1;
      end else begin
        best_rank_s = best_rank_s;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds dispatched ops, wakes operands from
// the CDB and issues the oldest ready op through a registered output stage.
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = alu_rs_pkg::COMMON_WIDTH,
  parameter int TAG_W   = alu_rs_pkg::INST_TAG_WIDTH,
  parameter int OP_W    = alu_rs_pkg::ALU_OP_WIDTH,
  parameter logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic [TAG_W-1:0]           disp_tag1,
  input  logic [TAG_W-1:0]           disp_tag2,
  input  logic [DATA_W-1:0]          disp_src1,
  input  logic [DATA_W-1:0]          disp_src2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [DATA_W-1:0]          iss_a,
  output logic [DATA_W-1:0]          iss_b,
  output logic [$clog2(ENTRIES):0]   occupancy
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int RANK_W = IDX_W;
  localparam int OCC_W  = IDX_W + 1;

  logic [ENTRIES-1:0]             busy_r;
  logic [ENTRIES-1:0][RANK_W-1:0] rank_r;
  logic [OP_W-1:0]                op_r   [ENTRIES];
  logic [TAG_W-1:0]               dtag_r [ENTRIES];
  logic [TAG_W-1:0]               q1_r   [ENTRIES];
  logic [TAG_W-1:0]               q2_r   [ENTRIES];
  logic [DATA_W-1:0]              v1_r   [ENTRIES];
  logic [DATA_W-1:0]              v2_r   [ENTRIES];
  logic [OCC_W-1:0]               occ_r;

  logic                           iss_valid_r;
  logic [OP_W-1:0]                iss_op_r;
  logic [TAG_W-1:0]               iss_tag_r;
  logic [DATA_W-1:0]              iss_a_r;
  logic [DATA_W-1:0]              iss_b_r;

  logic [ENTRIES-1:0]             ready_s;
  logic [IDX_W-1:0]               grant_s;
  logic                           any_ready_s;
  logic [IDX_W-1:0]               free_idx_s;
  logic                           free_found_s;
  logic                           disp_ready_s;
  logic                           fire_s;
  logic                           load_en_s;
  logic                           issue_s;
  logic [RANK_W-1:0]              leave_rank_s;
  logic [OCC_W-1:0]               occ_after_s;
  logic                           byp1_s;
  logic                           byp2_s;
  logic                           snoop_s;

  assign disp_ready_s = ~(&busy_r);
  assign fire_s       = disp_valid && disp_ready_s && !flush;
  assign load_en_s    = !iss_valid_r || iss_ready;
  assign issue_s      = load_en_s && any_ready_s;
  assign leave_rank_s = rank_r[grant_s];
  assign occ_after_s  = occ_r - OCC_W'(issue_s);
  assign snoop_s      = cdb_valid && (cdb_tag != TAG_INVALID);
  assign byp1_s       = snoop_s && (cdb_tag == disp_tag1);
  assign byp2_s       = snoop_s && (cdb_tag == disp_tag2);

  // Readiness is taken from registered operand tags only.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready_s[i] = busy_r[i] && (q1_r[i] == TAG_INVALID) && (q2_r[i] == TAG_INVALID);
    end
  end

  // Lowest-index free slot, based on registered busy bits.
  always_comb begin
    free_idx_s   = '0;
    free_found_s = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!busy_r[i] && !free_found_s) begin
        free_idx_s   = IDX_W'(i);
        free_found_s = 1'b1;
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  rs_select #(
    .ENTRIES (ENTRIES),
    .RANK_W  (RANK_W),
    .IDX_W   (IDX_W)
  ) u_select (
    .ready     (ready_s),
    .rank      (rank_r),
    .grant     (grant_s),
    .any_ready (any_ready_s)
  );

  // Slot array: free on issue, allocate on dispatch, age and snoop otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
      rank_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_r[i]   <= '0;
        dtag_r[i] <= '0;
        q1_r[i]   <= '0;
        q2_r[i]   <= '0;
        v1_r[i]   <= '0;
        v2_r[i]   <= '0;
      end
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (issue_s && (grant_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b0;
        end else if (fire_s && (free_idx_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b1;
          op_r[i]   <= disp_op;
          dtag_r[i] <= disp_tag;
          rank_r[i] <= occ_after_s[RANK_W-1:0];
          q1_r[i]   <= byp1_s ? TAG_INVALID : disp_tag1;
          v1_r[i]   <= byp1_s ? cdb_data : disp_src1;
          q2_r[i]   <= byp2_s ? TAG_INVALID : disp_tag2;
          v2_r[i]   <= byp2_s ? cdb_data : disp_src2;
        end else if (busy_r[i]) begin
          if (issue_s && (rank_r[i] > leave_rank_s)) begin
            rank_r[i] <= rank_r[i] - RANK_W'(1'b1);
          end
          if (snoop_s && (q1_r[i] == cdb_tag)) begin
            q1_r[i] <= TAG_INVALID;
            v1_r[i] <= cdb_data;
          end
          if (snoop_s && (q2_r[i] == cdb_tag)) begin
            q2_r[i] <= TAG_INVALID;
            v2_r[i] <= cdb_data;
          end
        end
      end
    end
  end

  // Busy-slot count; the output stage is not included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_after_s + OCC_W'(fire_s);
    end
  end

  // Output stage; payload holds while stalled by the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_r <= 1'b0;
      iss_op_r    <= '0;
      iss_tag_r   <= '0;
      iss_a_r     <= '0;
      iss_b_r     <= '0;
    end else if (flush) begin
      iss_valid_r <= 1'b0;
    end else if (load_en_s) begin
      if (any_ready_s) begin
        iss_valid_r <= 1'b1;
        iss_op_r    <= op_r[grant_s];
        iss_tag_r   <= dtag_r[grant_s];
        iss_a_r     <= v1_r[grant_s];
        iss_b_r     <= v2_r[grant_s];
      end else begin
        iss_valid_r <= 1'b0;
      end
    end
  end

  assign disp_ready = disp_ready_s;
  assign occupancy  = occ_r;
  assign iss_valid  = iss_valid_r;
  assign iss_op     = iss_op_r;
  assign iss_tag    = iss_tag_r;
  assign iss_a      = iss_a_r;
  assign iss_b      = iss_b_r;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: one task per scenario, hand-computed expectations.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_op;
  logic [3:0]  disp_tag, disp_tag1, disp_tag2;
  logic [31:0] disp_src1, disp_src2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_op;
  logic [3:0]  iss_tag;
  logic [31:0] iss_a, iss_b;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_tag(iss_tag), .iss_a(iss_a), .iss_b(iss_b), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_op = 6'h00; disp_tag = 4'h0;
    disp_tag1 = 4'hF; disp_tag2 = 4'hF; disp_src1 = 32'h0; disp_src2 = 32'h0;
    cdb_valid = 1'b0; cdb_tag = 4'hF; cdb_data = 32'h0;
  endtask

  task automatic disp(input logic [3:0] tg, input logic [3:0] t1, input logic [3:0] t2,
                      input logic [31:0] s1, input logic [31:0] s2);
    disp_valid = 1'b1; disp_op = 6'h01; disp_tag = tg;
    disp_tag1 = t1; disp_tag2 = t2; disp_src1 = s1; disp_src2 = s2;
  endtask

  task automatic drain();
    idle();
    iss_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    idle();
    iss_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_iss_valid got=%0h exp=0", iss_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL rst_disp_ready got=%0h exp=1", disp_ready); end
    total++; if ({iss_op, iss_tag, iss_a, iss_b} !== 74'h0) begin bad++; $display("FAIL rst_iss_data got=%0h exp=0", {iss_op, iss_tag, iss_a, iss_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ready_dispatch();
    iss_ready = 1'b1;
    disp(4'h2, 4'hF, 4'hF, 32'd5, 32'd7);
    tick();
    idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_early got=%0h exp=0", iss_valid); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL rd_occ1 got=%0d exp=1", occupancy); end
    tick();
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%0h exp=1", iss_valid); end
    total++; if (iss_a !== 32'd5 || iss_b !== 32'd7) begin bad++; $display("FAIL rd_ab got=%0h/%0h exp=5/7", iss_a, iss_b); end
    total++; if (iss_tag !== 4'h2 || iss_op !== 6'h01) begin bad++; $display("FAIL rd_tagop got=%0h/%0h exp=2/1", iss_tag, iss_op); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rd_occ0 got=%0d exp=0", occupancy); end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%0h exp=0", iss_valid); end
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    disp(4'h4, 4'h3, 4'hF, 32'hDEAD, 32'd9);
    tick();
    idle();
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wk_wait got=%0h exp=0", iss_valid); end
    cdb_valid = 1'b1; cdb_tag = 4'h3; cdb_data = 32'hAA;
    tick();
    idle();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wk_same_edge got=%0h exp=0", iss_valid); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'h4) begin bad++; $display("FAIL wk_issue got=%0h/%0h exp=1/4", iss_valid, iss_tag); end
    total++; if (iss_a !== 32'hAA || iss_b !== 32'd9) begin bad++; $display("FAIL wk_ab got=%0h/%0h exp=aa/9", iss_a, iss_b); end
  endtask

  task automatic test_bypass();
    iss_ready = 1'b1;
    disp(4'h5, 4'hF, 4'h6, 32'd1, 32'h99);
    cdb_valid = 1'b1; cdb_tag = 4'h6; cdb_data = 32'h55;
    tick();
    idle();
    tick();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'h5) begin bad++; $display("FAIL byp_issue got=%0h/%0h exp=1/5", iss_valid, iss_tag); end
    total++; if (iss_a !== 32'd1 || iss_b !== 32'h55) begin bad++; $display("FAIL byp_ab got=%0h/%0h exp=1/55", iss_a, iss_b); end
  endtask

  task automatic test_age_order();
    iss_ready = 1'b0;
    disp(4'hA, 4'h1, 4'hF, 32'hDEAD, 32'h22);
    tick();
    disp(4'hB, 4'hF, 4'hF, 32'hB0, 32'hB1);
    tick();
    disp(4'hC, 4'hF, 4'hF, 32'hC0, 32'hC1);
    tick();
    idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'hB) begin bad++; $display("FAIL age_first got=%0h/%0h exp=1/b", iss_valid, iss_tag); end
    tick();
    total++; if (iss_tag !== 4'hB || iss_a !== 32'hB0) begin bad++; $display("FAIL age_hold got=%0h/%0h exp=b/b0", iss_tag, iss_a); end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL age_occ got=%0d exp=2", occupancy); end
    cdb_valid = 1'b1; cdb_tag = 4'h1; cdb_data = 32'h11;
    iss_ready = 1'b1;
    tick();
    idle();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'hC) begin bad++; $display("FAIL age_second got=%0h/%0h exp=1/c", iss_valid, iss_tag); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_tag !== 4'hA) begin bad++; $display("FAIL age_third got=%0h/%0h exp=1/a", iss_valid, iss_tag); end
    total++; if (iss_a !== 32'h11 || iss_b !== 32'h22) begin bad++; $display("FAIL age_ab got=%0h/%0h exp=11/22", iss_a, iss_b); end
    tick();
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL age_empty got=%0h/%0d exp=0/0", iss_valid, occupancy); end
  endtask

  task automatic test_full_backpressure();
    logic [3:0] exp_tag;
    iss_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      disp(4'(k), 4'hF, 4'hF, 32'(k * 16), 32'(k));
      tick();
    end
    disp(4'h6, 4'hF, 4'hF, 32'h60, 32'h6);
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_disp_ready got=%0h exp=0", disp_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (iss_valid !== 1'b1 || iss_tag !== 4'h1 || iss_a !== 32'h10) begin bad++; $display("FAIL full_hold c=%0d got=%0h/%0h/%0h exp=1/1/10", c, iss_valid, iss_tag, iss_a); end
      total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_drop c=%0d got=%0d exp=4", c, occupancy); end
    end
    idle();
    iss_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_tag = 4'(k);
      total++; if (iss_valid !== 1'b1 || iss_tag !== exp_tag) begin bad++; $display("FAIL full_drain k=%0d got=%0h/%0h exp=1/%0h", k, iss_valid, iss_tag, exp_tag); end
    end
    tick();
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL full_empty got=%0h/%0d exp=0/0", iss_valid, occupancy); end
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      disp(4'(k), 4'hF, 4'hF, 32'(k), 32'(k));
      tick();
    end
    total++; if (occupancy !== 3'd3 || iss_valid !== 1'b1) begin bad++; $display("FAIL fl_pre got=%0d/%0h exp=3/1", occupancy, iss_valid); end
    disp(4'h7, 4'hF, 4'hF, 32'h7, 32'h7);
    cdb_valid = 1'b1; cdb_tag = 4'h2; cdb_data = 32'h77;
    flush = 1'b1;
    tick();
    idle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL fl_occ got=%0d exp=0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", iss_valid); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL fl_disp_ready got=%0h exp=1", disp_ready); end
    iss_ready = 1'b1;
    tick();
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL fl_after got=%0h/%0d exp=0/0", iss_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    iss_ready = 1'b0;
    disp(4'h9, 4'hF, 4'hF, 32'h99, 32'h98);
    tick();
    disp(4'h8, 4'hF, 4'hF, 32'h88, 32'h87);
    tick();
    idle();
    total++; if (iss_valid !== 1'b1 || occupancy !== 3'd1) begin bad++; $display("FAIL ar_pre got=%0h/%0d exp=1/1", iss_valid, occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h exp=0", iss_valid); end
    total++; if (iss_a !== 32'h0 || iss_tag !== 4'h0) begin bad++; $display("FAIL ar_data got=%0h/%0h exp=0/0", iss_a, iss_tag); end
    total++; if (occupancy !== 3'd0 || disp_ready !== 1'b1) begin bad++; $display("FAIL ar_occ got=%0d/%0h exp=0/1", occupancy, disp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    drain();
    test_wakeup();
    drain();
    test_bypass();
    drain();
    test_age_order();
    drain();
    test_full_backpressure();
    drain();
    test_flush();
    drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
